// File: rtl/pa_pipe_core.sv
// pa_pipe_core: three-stage register-operand datapath (ID -> OP -> EX/WB).
// An instruction is accepted into ID, reads its operands there, the ALU
// works combinationally from OP, and EX drives the writeback monitor and
// writes the register file on the following edge.
// Compile-time option: define PA_FORWARD_EN to resolve read-after-write
// hazards by forwarding (never stalls). Default build stalls ID until the
// producer has written the register file.
//
// Handshake: an instruction transfers on a rising edge where
// in_valid && in_ready. in_ready never depends on in_valid; a source holding
// in_valid high with in_ready low must keep in_instr stable until accepted.
module pa_pipe_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int INSTR_W = 3 + 3 * ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               wb_valid,
  output logic [ADDR_W-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;

  // ID stage
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [2:0]         id_op;
  logic [ADDR_W-1:0]  id_rd, id_rs, id_rt;
  logic [DATA_W-1:0]  id_imm, rf_a, rf_b, src_a, src_b, id_a;
  logic               stall, accept;

  // OP stage
  logic               op_valid;
  logic [2:0]         op_op;
  logic [ADDR_W-1:0]  op_rd;
  logic [DATA_W-1:0]  op_a, op_b, alu_res;
  logic               op_writes;

  // EX stage
  logic               ex_valid;
  logic [ADDR_W-1:0]  ex_rd;
  logic [DATA_W-1:0]  ex_res;

  logic [DATA_W-1:0]  rf [NREG];

  assign id_op  = id_instr[INSTR_W-1 -: 3];
  assign id_rd  = id_instr[3*ADDR_W-1 -: ADDR_W];
  assign id_rs  = id_instr[2*ADDR_W-1 -: ADDR_W];
  assign id_rt  = id_instr[ADDR_W-1:0];
  assign id_imm = DATA_W'({id_rs, id_rt});

  // r0 is hardwired to zero on every read path.
  assign rf_a     = (id_rs == '0) ? '0 : rf[id_rs];
  assign rf_b     = (id_rt == '0) ? '0 : rf[id_rt];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  // NOPs (110, 111) travel through OP but never become writers.
  assign op_writes = op_valid && (op_op <= OP_LDI);

`ifdef PA_FORWARD_EN
  // Operand bypass: the OP ALU output is the youngest value, so it wins over EX.
  always_comb begin
    src_a = rf_a;
    src_b = rf_b;
    if (ex_valid && ex_rd != '0 && ex_rd == id_rs) src_a = ex_res;
    if (ex_valid && ex_rd != '0 && ex_rd == id_rt) src_b = ex_res;
    if (op_writes && op_rd != '0 && op_rd == id_rs) src_a = alu_res;
    if (op_writes && op_rd != '0 && op_rd == id_rt) src_b = alu_res;
    stall = 1'b0;
  end
`else
  // Hazard detect: hold a register-reading ID instruction while any younger-
  // than-file writer to one of its sources is still in OP or EX.
  always_comb begin
    logic reads, hit_op, hit_ex;
    src_a  = rf_a;
    src_b  = rf_b;
    reads  = (id_op <= OP_XOR);
    hit_op = op_writes && op_rd != '0 && (op_rd == id_rs || op_rd == id_rt);
    hit_ex = ex_valid && ex_rd != '0 && (ex_rd == id_rs || ex_rd == id_rt);
    stall  = id_valid && reads && (hit_op || hit_ex);
  end
`endif

  // LDI carries its operand in the rs/rt fields instead of reading registers.
  assign id_a = (id_op == OP_LDI) ? id_imm : src_a;

  assign in_ready = rst_n && !flush && (!id_valid || !stall);
  assign accept   = in_valid && in_ready;

  // ALU, combinational from OP; arithmetic wraps modulo 2**DATA_W.
  always_comb begin
    alu_res = '0;
    case (op_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_LDI:  alu_res = op_a;
      default: alu_res = '0;
    endcase
  end

  // ID register: load on accept, hold on stall, empty otherwise; flush clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (accept) begin
      id_valid <= 1'b1;
      id_instr <= in_instr;
    end else if (!stall) begin
      id_valid <= 1'b0;
    end
  end

  // OP register: takes ID unless stalled (bubble) or flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_op    <= '0;
      op_rd    <= '0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      op_valid <= id_valid && !stall && !flush;
      op_op    <= id_op;
      op_rd    <= id_rd;
      op_a     <= id_a;
      op_b     <= src_b;
    end
  end

  // EX register: the OP instruction always advances, even across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      ex_res   <= '0;
    end else begin
      ex_valid <= op_writes;
      ex_rd    <= op_rd;
      ex_res   <= alu_res;
    end
  end

  assign wb_valid = ex_valid;
  assign wb_addr  = ex_rd;
  assign wb_data  = ex_res;

  // Register file write; r0 writes are reported on wb_* but dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (ex_valid && ex_rd != '0) begin
      rf[ex_rd] <= ex_res;
    end
  end

endmodule

// File: tb/tb_pa_pipe_core.sv
module tb_pa_pipe_core;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int IW     = 3 + 3 * ADDR_W;
  localparam int NREG   = 1 << ADDR_W;
  localparam int NMIX   = 20;
`ifdef PA_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [IW-1:0]     in_instr = '0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;

  pa_pipe_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(negedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: {addr, data} of every writeback, in program order
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]        ref_rf [NREG];

  function automatic logic [DATA_W-1:0] ref_alu(input logic [2:0] op,
      input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
    logic [DATA_W-1:0] a, b;
    a = ref_rf[rs];
    b = ref_rf[rt];
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return DATA_W'({rs, rt});
      default: return '0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) check_eq("wb_unexpected", {wb_addr, wb_data}, '1);
      else check_eq("wb", {wb_addr, wb_data}, exp_q.pop_front());
    end
  end

  // driver: offer one instruction, hold it until accepted
  task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] rd,
      input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
      input bit model, output int waits, output int acc_cyc);
    bit rdy;
    logic [DATA_W-1:0] res;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {op, rd, rs, rt};
    waits = 0;
    forever begin
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        check_eq("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    acc_cyc = cyc;
    if (model && op <= 3'd5) begin
      res = ref_alu(op, rs, rt);
      exp_q.push_back({rd, res});
      if (rd != '0) ref_rf[rd] = res;
    end
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (exp_q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reg(input string tag, input int a, input logic [DATA_W-1:0] exp);
    dbg_addr = ADDR_W'(a);
    #1 check_eq(tag, 64'(dbg_data), 64'(exp));
  endtask

  int w, c;
  logic [2:0]        mop [NMIX];
  logic [ADDR_W-1:0] mrd [NMIX], mrs [NMIX], mrt [NMIX];
  int                t_exp [NMIX], d_exp [NMIX], t_obs [NMIX];

  initial begin
    for (int i = 0; i < NREG; i++) ref_rf[i] = '0;

    // reset state
    #3;
    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_reg("rst_r1", 1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("post_rst_ready", 64'(in_ready), 64'd1);

    // back-to-back RAW; the NOP behind the ADD sees the stall
    send(3'd5, 5'd1, 5'd0, 5'd5, 1'b1, w, c);
    send(3'd5, 5'd2, 5'd0, 5'd3, 1'b1, w, c);
    send(3'd0, 5'd3, 5'd1, 5'd2, 1'b1, w, c);
    check_eq("raw_add_wait", 64'(w), 64'd0);
    send(3'd6, 5'd0, 5'd0, 5'd0, 1'b1, w, c);
    check_eq("raw_stall_cycles", 64'(w), FWD ? 64'd0 : 64'd2);
    drain();
    check_reg("raw_r3", 3, 32'd8);

    // wrap-around
    send(3'd1, 5'd4, 5'd0, 5'd1, 1'b1, w, c);
    send(3'd5, 5'd8, 5'd0, 5'd0, 1'b1, w, c);
    send(3'd5, 5'd9, 5'd0, 5'd1, 1'b1, w, c);
    send(3'd1, 5'd10, 5'd8, 5'd9, 1'b1, w, c);
    send(3'd0, 5'd11, 5'd10, 5'd9, 1'b1, w, c);
    drain();
    check_reg("wrap_sub", 4, 32'hFFFF_FFFB);
    check_reg("wrap_allones", 10, 32'hFFFF_FFFF);
    check_reg("wrap_add", 11, 32'd0);

    // r0 write is reported but not stored or forwarded
    send(3'd5, 5'd0, 5'd0, 5'd7, 1'b1, w, c);
    send(3'd0, 5'd5, 5'd0, 5'd0, 1'b1, w, c);
    drain();
    check_reg("r0_dbg", 0, '0);
    check_reg("r0_r5", 5, '0);

    // flush: r6 commits, r7 is discarded, nothing accepted in the flush cycle
    send(3'd5, 5'd6, 5'd0, 5'd9, 1'b1, w, c);
    send(3'd5, 5'd7, 5'd0, 5'd4, 1'b0, w, c);
    check_eq("flush_r7_wait", 64'(w), 64'd0);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = {3'd5, 5'd7, 5'd0, 5'd4};
    #1 check_eq("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    drain();
    check_reg("flush_r6", 6, 32'd9);
    check_reg("flush_r7", 7, '0);

    // mixed random stream with dependences over r0..r7
    for (int i = 0; i < NMIX; i++) begin
      mop[i] = 3'($urandom_range(0, 7));
      mrd[i] = ADDR_W'($urandom_range(0, 7));
      mrs[i] = ADDR_W'($urandom_range(0, 7));
      mrt[i] = ADDR_W'($urandom_range(0, 7));
    end
    // acceptance schedule: ID leaves no earlier than 3 edges after a producer left ID
    for (int i = 0; i < NMIX; i++) begin
      t_exp[i] = (i == 0) ? 0 : d_exp[i-1];
      d_exp[i] = t_exp[i] + 1;
      if (!FWD) begin
        for (int j = 0; j < i; j++) begin
          if (mop[j] <= 3'd5 && mrd[j] != '0 && mop[i] <= 3'd4 &&
              (mrs[i] == mrd[j] || mrt[i] == mrd[j]) && d_exp[j] + 3 > d_exp[i])
            d_exp[i] = d_exp[j] + 3;
        end
      end
    end
    for (int i = 0; i < NMIX; i++) send(mop[i], mrd[i], mrs[i], mrt[i], 1'b1, w, t_obs[i]);
    drain();
    check_eq("mix_cycles", 64'(t_obs[NMIX-1] - t_obs[0]), 64'(t_exp[NMIX-1] - t_exp[0]));
    for (int r = 0; r < 8; r++) check_reg($sformatf("mix_r%0d", r), r, ref_rf[r]);

    // reset mid-stream: nothing in flight may commit
    send(3'd5, 5'd12, 5'd0, 5'd1, 1'b0, w, c);
    send(3'd5, 5'd13, 5'd0, 5'd2, 1'b0, w, c);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("midrst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    for (int r = 0; r < NREG; r++) check_reg($sformatf("midrst_r%0d", r), r, '0);
    exp_q.delete();
    for (int i = 0; i < NREG; i++) ref_rf[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("midrst_release_ready", 64'(in_ready), 64'd1);
    repeat (6) @(negedge clk);
    check_reg("midrst_r12", 12, '0);
    check_reg("midrst_r13", 13, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pa_pipe_core.md
# pa_pipe_core

Parametrised three-stage register-operand datapath (ID → OP → EX/WB) for the pipelined-add subsystem. Accepts one instruction per cycle over a valid/ready handshake, reads an internal register file, executes a small ALU operation set and writes results back. Handles read-after-write hazards by forwarding or by stalling, selected at compile time. Exposes a writeback monitor and a debug read port for the bench.

## Interface
- `DATA_W`, default 32: register and ALU width.
- `ADDR_W`, default 5: register address width.
  - Register file holds 2**ADDR_W entries.
  - Instruction width is INSTR_W = 3 + 3*ADDR_W.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: `in_instr` is valid.
- `in_instr` input, INSTR_W bits: instruction, packed as {op[2:0], rd, rs, rt}, op in the MSBs.
- `in_ready` output, 1 bit: core accepts `in_instr` this cycle.
- `flush` input, 1 bit: discard uncommitted instructions.
- `wb_valid` output, 1 bit: a writeback occurs at the next rising edge.
- `wb_addr` output, ADDR_W bits: writeback destination.
- `wb_data` output, DATA_W bits: writeback value.
- `dbg_addr` input, ADDR_W bits: debug read address.
- `dbg_data` output, DATA_W bits: combinational register file read.
  - Returns 0 for r0.

## Operation
- Opcodes:
  - 000 ADD: rd = rs + rt.
  - 001 SUB: rd = rs − rt.
  - 010 AND: rd = rs & rt.
  - 011 OR: rd = rs | rt.
  - 100 XOR: rd = rs ^ rt.
  - 101 LDI: rd = zero-extended {rs, rt} immediate; reads no registers.
  - 110, 111 NOP: flow through the pipe and never assert `wb_valid`.
- Arithmetic is modulo 2**DATA_W; SUB is two's complement. No flags.
- r0 reads as 0. Writes to r0 assert `wb_valid` but leave the file unchanged.
- Pipeline stages:
  - ID: holds the accepted instruction and reads operands.
  - OP: holds op, rd and the two operands; the ALU is combinational from OP.
  - EX: holds result and rd; drives `wb_*` and writes the register file on the next edge.
- Hazard definition: a reader in ID conflicts with a valid writer in OP or EX whose rd ≠ 0 equals rs or rt. LDI and NOP readers never conflict.
- Hazard resolution is governed by `PA_FORWARD_EN` (see Configuration).
- Stall behaviour:
  - ID holds its contents and OP receives a bubble.
  - `in_ready = !id_valid || !stall`, and is forced 0 while `flush` = 1.
- Flush behaviour:
  - `flush` clears the ID and OP valid bits at the edge.
  - The EX instruction still commits.
  - No instruction is accepted in the flush cycle.
- Reset (rst_n low, asynchronous):
  - All stage valid bits, the register file, `wb_valid`, `wb_addr` and `wb_data` go to 0.
  - `in_ready` = 0 while in reset, and 1 in the first cycle after release.
  - Reset mid-operation discards all in-flight instructions; none commits.

## Timing
- Instruction accepted at edge E0 (in_valid && in_ready).
  - E1: OP latched.
  - E2: EX latched; `wb_*` valid during cycle E2–E3.
  - E3: register file written.
- Latency accept-to-commit is 3 edges. Throughput is 1 per cycle when hazard-free.
- `dbg_data` reflects a write from edge E3 onward.
- Stalls, without forwarding:
  - Dependent instruction immediately following its producer: 2 stall cycles.
  - One instruction gap: 1 stall cycle.
  - Two or more instructions gap: none.
- Simultaneous `flush` and stall: flush wins. ID is cleared and no stall is held.
- `in_instr` must stay stable while `in_valid` = 1 and `in_ready` = 0; the core never drops an offered instruction.

## Configuration
- `PA_FORWARD_EN` defined:
  - ID operands are taken with priority OP ALU output, then EX result, then register file.
  - Never stalls; `in_ready` = 1 whenever `flush` = 0.
- `PA_FORWARD_EN` undefined:
  - A hazard asserts stall until the producer has written the file.
  - Operands always come from the register file.
  - Stall counts are as in Timing.

## Test plan
- Reset: drive instructions, pulse rst_n low mid-stream → `wb_valid` = 0 and every `dbg_data` = 0. After release, `in_ready` = 1 and no stale writeback appears.
- Back-to-back RAW: LDI r1,5; LDI r2,3; ADD r3,r1,r2 on consecutive cycles → `wb_data` = 8 at addr 3.
  - With forwarding: `in_ready` stays 1.
  - Without: `in_ready` low for 2 cycles and the ADD is held, not lost.
- Wrap: after r1 = 5, SUB r4,r0,r1 → `wb_data` = 0xFFFFFFFB (DATA_W = 32). ADD of 0xFFFFFFFF + 1 via LDI-built operands → 0.
- r0 write: LDI r0,7 then ADD r5,r0,r0 back-to-back → `wb_valid` = 1 with addr 0 for the LDI. r5 = 0, `dbg_data`(r0) = 0; no forwarding of the r0 write.
- Flush: LDI r6,9 accepted, LDI r7,4 accepted next cycle, flush asserted the following cycle → r6 = 9 commits, r7 stays 0, and `in_ready` = 0 during the flush cycle.
- Mixed stream: 20 random ops with random dependences, run in both configurations → final register file matches a sequential reference model, and no-forward cycle count ≥ forward cycle count.
